// File: rtl/ptc_ramp_seq.sv
// Wishbone master that initialises one PTC timer and ramps its PWM duty (HRC)
// from the current value to a target in saturating steps at a fixed interval.
module ptc_ramp_seq #(
   parameter int unsigned ADR_W   = 8,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned DW      = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [DW-1:0]    period_i,
   input  logic [DW-1:0]    target_i,
   input  logic [DW-1:0]    step_i,
   input  logic [DW-1:0]    interval_i,
   output logic             m_cyc_o,
   output logic             m_stb_o,
   output logic             m_we_o,
   output logic [ADR_W-1:0] m_adr_o,
   output logic [31:0]      m_dat_o,
   output logic [3:0]       m_sel_o,
   input  logic             m_ack_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [DW-1:0]    duty_o
);

   localparam int unsigned TO_W = 16;

   localparam logic [ADR_W-1:0] ADR_HRC  = ADR_W'(4);
   localparam logic [ADR_W-1:0] ADR_LRC  = ADR_W'(8);
   localparam logic [ADR_W-1:0] ADR_CTRL = ADR_W'(12);

   localparam logic [31:0] CTRL_RST = 32'h0000_0080;
   localparam logic [31:0] CTRL_EN  = 32'h0000_0009;
   localparam logic [31:0] CTRL_OFF = 32'h0000_0000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_RST,
      S_W_LRC,
      S_W_HRC,
      S_W_EN,
      S_WAIT,
      S_W_STEP,
      S_HOLD,
      S_W_OFF
   } state_t;

   state_t            r_state, w_state_nxt, w_adv;
   logic              r_stb, w_stb_nxt;
   logic [ADR_W-1:0]  r_adr, w_adr_nxt;
   logic [31:0]       r_dat, w_dat_nxt;
   logic [DW-1:0]     r_period, w_period_nxt;
   logic [DW-1:0]     r_target, w_target_nxt;
   logic [DW-1:0]     r_step, w_step_nxt;
   logic [DW-1:0]     r_interval, w_interval_nxt;
   logic [DW-1:0]     r_cur, w_cur_nxt;
   logic [DW-1:0]     r_duty, w_duty_nxt;
   logic [DW-1:0]     r_wait_cnt, w_wait_nxt;
   logic [TO_W-1:0]   r_to_cnt, w_to_nxt;
   logic              r_err, w_err_nxt;
   logic              r_stop_pend, w_pend_nxt;
   logic              r_busy, r_done;
   logic              w_launch;
   logic              w_stop;
   logic [DW-1:0]     w_step_eff;
   logic [DW-1:0]     w_ivl_last;
   logic [DW-1:0]     w_next;

   assign w_stop     = stop_i | r_stop_pend;
   assign w_step_eff = (r_step == '0) ? DW'(1) : r_step;
   assign w_ivl_last = (r_interval == '0) ? '0 : r_interval - DW'(1);

   // Next duty value, saturating at the target from either direction
   always_comb begin
      w_next = r_cur;
      if (r_target > r_cur) begin
         w_next = ((r_target - r_cur) <= w_step_eff) ? r_target : r_cur + w_step_eff;
      end else if (r_target < r_cur) begin
         w_next = ((r_cur - r_target) <= w_step_eff) ? r_target : r_cur - w_step_eff;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_adv          = S_IDLE;
      w_stb_nxt      = r_stb;
      w_adr_nxt      = r_adr;
      w_dat_nxt      = r_dat;
      w_period_nxt   = r_period;
      w_target_nxt   = r_target;
      w_step_nxt     = r_step;
      w_interval_nxt = r_interval;
      w_cur_nxt      = r_cur;
      w_duty_nxt     = r_duty;
      w_wait_nxt     = r_wait_cnt;
      w_err_nxt      = r_err;
      w_pend_nxt     = r_stop_pend;
      w_to_nxt       = '0;
      w_launch       = 1'b0;

      if (r_stb && !m_ack_i) begin
         w_to_nxt = r_to_cnt + TO_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (start_i && !stop_i) begin
               w_period_nxt   = period_i;
               w_target_nxt   = target_i;
               w_step_nxt     = step_i;
               w_interval_nxt = interval_i;
               w_err_nxt      = 1'b0;
               w_cur_nxt      = '0;
               w_state_nxt    = S_W_RST;
               w_launch       = 1'b1;
            end
         end
         S_HOLD: begin
            if (stop_i) begin
               w_state_nxt = S_W_OFF;
               w_launch    = 1'b1;
            end else if (start_i) begin
               // Retarget: the PTC keeps its period and stays enabled
               w_target_nxt   = target_i;
               w_step_nxt     = step_i;
               w_interval_nxt = interval_i;
               if (target_i != r_cur) begin
                  w_state_nxt = S_WAIT;
                  w_wait_nxt  = '0;
               end
            end
         end
         S_WAIT: begin
            if (stop_i) begin
               w_state_nxt = S_W_OFF;
               w_launch    = 1'b1;
            end else if (r_wait_cnt >= w_ivl_last) begin
               w_state_nxt = S_W_STEP;
               w_launch    = 1'b1;
            end else begin
               w_wait_nxt = r_wait_cnt + DW'(1);
            end
         end
         default: begin
            if (r_stb) begin
               if (stop_i) begin
                  w_pend_nxt = 1'b1;
               end
               if (m_ack_i) begin
                  w_stb_nxt  = 1'b0;
                  w_pend_nxt = 1'b0;
                  w_wait_nxt = '0;
                  case (r_state)
                     S_W_RST: w_adv = S_W_LRC;
                     S_W_LRC: w_adv = S_W_HRC;
                     S_W_HRC: begin
                        w_duty_nxt = r_cur;
                        w_adv      = S_W_EN;
                     end
                     S_W_EN:  w_adv = (r_cur == r_target) ? S_HOLD : S_WAIT;
                     S_W_STEP: begin
                        w_cur_nxt  = w_next;
                        w_duty_nxt = w_next;
                        w_adv      = (w_next == r_target) ? S_HOLD : S_WAIT;
                     end
                     S_W_OFF: begin
                        w_cur_nxt  = '0;
                        w_duty_nxt = '0;
                        w_adv      = S_IDLE;
                     end
                     default: w_adv = S_IDLE;
                  endcase
                  w_state_nxt = (w_stop && r_state != S_W_OFF) ? S_W_OFF : w_adv;
               end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                  // Slave is unresponsive: abandon, flag, and skip the off write
                  w_stb_nxt   = 1'b0;
                  w_err_nxt   = 1'b1;
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end
            end else if (stop_i && r_state != S_W_OFF) begin
               w_state_nxt = S_W_OFF;
               w_launch    = 1'b1;
            end else begin
               w_launch = 1'b1;
            end
         end
      endcase

      if (w_launch) begin
         w_stb_nxt = 1'b1;
         case (w_state_nxt)
            S_W_RST: begin
               w_adr_nxt = ADR_CTRL;
               w_dat_nxt = CTRL_RST;
            end
            S_W_LRC: begin
               w_adr_nxt = ADR_LRC;
               w_dat_nxt = 32'(r_period);
            end
            S_W_HRC: begin
               w_adr_nxt = ADR_HRC;
               w_dat_nxt = 32'(r_cur);
            end
            S_W_EN: begin
               w_adr_nxt = ADR_CTRL;
               w_dat_nxt = CTRL_EN;
            end
            S_W_STEP: begin
               w_adr_nxt = ADR_HRC;
               w_dat_nxt = 32'(w_next);
            end
            S_W_OFF: begin
               w_adr_nxt = ADR_CTRL;
               w_dat_nxt = CTRL_OFF;
            end
            default: w_stb_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state     <= S_IDLE;
         r_stb       <= 1'b0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_period    <= '0;
         r_target    <= '0;
         r_step      <= '0;
         r_interval  <= '0;
         r_cur       <= '0;
         r_duty      <= '0;
         r_wait_cnt  <= '0;
         r_to_cnt    <= '0;
         r_err       <= 1'b0;
         r_stop_pend <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_stb       <= w_stb_nxt;
         r_adr       <= w_adr_nxt;
         r_dat       <= w_dat_nxt;
         r_period    <= w_period_nxt;
         r_target    <= w_target_nxt;
         r_step      <= w_step_nxt;
         r_interval  <= w_interval_nxt;
         r_cur       <= w_cur_nxt;
         r_duty      <= w_duty_nxt;
         r_wait_cnt  <= w_wait_nxt;
         r_to_cnt    <= w_to_nxt;
         r_err       <= w_err_nxt;
         r_stop_pend <= w_pend_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_HOLD);
      end
   end

   assign m_cyc_o = r_stb;
   assign m_stb_o = r_stb;
   assign m_we_o  = r_stb;
   assign m_sel_o = {4{r_stb}};
   assign m_adr_o = r_adr;
   assign m_dat_o = r_dat;
   assign busy_o  = r_busy;
   assign done_o  = r_done;
   assign err_o   = r_err;
   assign duty_o  = r_duty;

endmodule

// File: tb/tb_ptc_ramp_seq.sv
// Directed bench for ptc_ramp_seq: a Wishbone slave model logs acked writes,
// and each scenario task compares the log and status outputs to hand values.
module tb_ptc_ramp_seq;

   localparam int unsigned DW    = 16;
   localparam int unsigned ADR_W = 8;
   localparam int unsigned TMO   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i, stop_i;
   logic [DW-1:0]    period_i, target_i, step_i, interval_i;
   logic             m_cyc_o, m_stb_o, m_we_o;
   logic [ADR_W-1:0] m_adr_o;
   logic [31:0]      m_dat_o;
   logic [3:0]       m_sel_o;
   logic             m_ack_i;
   logic             busy_o, done_o, err_o;
   logic [DW-1:0]    duty_o;

   int checks = 0;
   int errors = 0;

   int   ack_delay = 1;
   bit   nack_en   = 1'b0;
   int   run_len   = 0;
   int   last_run  = 0;
   int   gap       = 100;
   int   launches  = 0;
   bit   proto_bad = 1'b0;
   int   cyc_cnt   = 0;
   logic [7:0]  wr_adr[$];
   logic [31:0] wr_dat[$];
   int          wr_cyc[$];

   ptc_ramp_seq #(.ADR_W(ADR_W), .TIMEOUT(TMO), .DW(DW)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .period_i   (period_i),
      .target_i   (target_i),
      .step_i     (step_i),
      .interval_i (interval_i),
      .m_cyc_o    (m_cyc_o),
      .m_stb_o    (m_stb_o),
      .m_we_o     (m_we_o),
      .m_adr_o    (m_adr_o),
      .m_dat_o    (m_dat_o),
      .m_sel_o    (m_sel_o),
      .m_ack_i    (m_ack_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .duty_o     (duty_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   // Slave model: acks after ack_delay+1 strobe cycles, optionally never for LRC
   always @(negedge clk) begin
      if (!m_stb_o) begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
         m_ack_i = 1'b0;
         gap++;
      end else begin
         if (run_len == 0) begin
            if (gap < 1) proto_bad = 1'b1;
            launches++;
            gap = 0;
         end
         if (!m_we_o || !m_cyc_o || m_sel_o != 4'hF) proto_bad = 1'b1;
         run_len++;
         if (!(nack_en && m_adr_o == 8'h08) && run_len > ack_delay) begin
            m_ack_i = 1'b1;
            wr_adr.push_back(m_adr_o);
            wr_dat.push_back(m_dat_o);
            wr_cyc.push_back(cyc_cnt);
         end else begin
            m_ack_i = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wr_adr.delete();
      wr_dat.delete();
      wr_cyc.delete();
      launches = 0;
   endtask

   task automatic pulse_start(input logic [15:0] p, input logic [15:0] t,
                              input logic [15:0] s, input logic [15:0] iv);
      @(negedge clk);
      period_i = p; target_i = t; step_i = s; interval_i = iv;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (!done_o && n < maxc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL wait_done: done_o=%0b after %0d cycles, required 1", done_o, n);
      end
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (busy_o && n < maxc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy_o=%0b after %0d cycles, required 0", busy_o, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; stop_i = 1'b0;
      period_i = '0; target_i = '0; step_i = '0; interval_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_cyc_o, m_stb_o, m_we_o, m_sel_o, busy_o, done_o, err_o} !== 10'b0) begin
         errors++;
         $display("FAIL reset_ctrl: cyc/stb/we/sel/busy/done/err=%b, required 0",
                  {m_cyc_o, m_stb_o, m_we_o, m_sel_o, busy_o, done_o, err_o});
      end
      checks++;
      if (duty_o !== 16'd0 || m_adr_o !== 8'd0 || m_dat_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: duty=%0d adr=%h dat=%h, required 0", duty_o, m_adr_o, m_dat_o);
      end
      rst = 1'b0;
      @(negedge clk);
      start_i = 1'b1; stop_i = 1'b1; target_i = 16'd5; period_i = 16'd9;
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || m_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_start_stop: busy=%0b stb=%0b, required 0/0", busy_o, m_stb_o);
      end
   endtask

   task automatic test_basic_ramp();
      logic [7:0]  ea [0:8];
      logic [31:0] ed [0:8];
      ea = '{8'h0C, 8'h08, 8'h04, 8'h0C, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};
      ed = '{32'h80, 32'd1000, 32'd0, 32'h09, 32'd100, 32'd200, 32'd300, 32'd400, 32'd500};
      clear_log();
      ack_delay = 1;
      pulse_start(16'd1000, 16'd500, 16'd100, 16'd10);
      checks++;
      if (m_stb_o !== 1'b1 || m_adr_o !== 8'h0C || m_dat_o !== 32'h80) begin
         errors++;
         $display("FAIL first_stb: stb=%0b adr=%h dat=%h, required 1/0c/80", m_stb_o, m_adr_o, m_dat_o);
      end
      wait_done(400);
      checks++;
      if (wr_adr.size() != 9) begin
         errors++;
         $display("FAIL ramp_count: %0d writes, required 9", wr_adr.size());
      end
      for (int i = 0; i < 9 && i < wr_adr.size(); i++) begin
         checks++;
         if (wr_adr[i] !== ea[i] || wr_dat[i] !== ed[i]) begin
            errors++;
            $display("FAIL ramp_write[%0d]: adr=%h dat=%0d, required adr=%h dat=%0d",
                     i, wr_adr[i], wr_dat[i], ea[i], ed[i]);
         end
      end
      for (int i = 4; i < 9 && i < wr_cyc.size(); i++) begin
         checks++;
         if (wr_cyc[i] - wr_cyc[i-1] < 11) begin
            errors++;
            $display("FAIL ramp_spacing[%0d]: %0d cycles, required >= 11", i, wr_cyc[i] - wr_cyc[i-1]);
         end
      end
      checks++;
      if (duty_o !== 16'd500 || busy_o !== 1'b1 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL ramp_final: duty=%0d busy=%0b err=%0b, required 500/1/0", duty_o, busy_o, err_o);
      end
   endtask

   task automatic test_retarget_down();
      clear_log();
      pulse_start(16'd999, 16'd120, 16'd200, 16'd4);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL retarget_leave_hold: done=%0b busy=%0b, required 0/1", done_o, busy_o);
      end
      wait_done(200);
      checks++;
      if (wr_adr.size() != 2) begin
         errors++;
         $display("FAIL retarget_count: %0d writes, required 2", wr_adr.size());
      end else begin
         checks++;
         if (wr_adr[0] !== 8'h04 || wr_dat[0] !== 32'd300 || wr_adr[1] !== 8'h04 || wr_dat[1] !== 32'd120) begin
            errors++;
            $display("FAIL retarget_writes: (%h,%0d) (%h,%0d), required (04,300) (04,120)",
                     wr_adr[0], wr_dat[0], wr_adr[1], wr_dat[1]);
         end
      end
      checks++;
      if (duty_o !== 16'd120) begin
         errors++;
         $display("FAIL retarget_duty: duty=%0d, required 120", duty_o);
      end
   endtask

   task automatic test_stop_mid_write();
      int n = 0;
      clear_log();
      ack_delay = 5;
      pulse_start(16'd0, 16'd300, 16'd180, 16'd2);
      while (!(m_stb_o && m_adr_o == 8'h04) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (m_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL stop_find_hrc: stb=%0b, required 1", m_stb_o);
      end
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      checks++;
      if (m_stb_o !== 1'b1 || m_adr_o !== 8'h04) begin
         errors++;
         $display("FAIL stop_keeps_write: stb=%0b adr=%h, required 1/04", m_stb_o, m_adr_o);
      end
      wait_idle(100);
      checks++;
      if (wr_adr.size() != 2) begin
         errors++;
         $display("FAIL stop_count: %0d writes, required 2", wr_adr.size());
      end else begin
         checks++;
         if (wr_adr[0] !== 8'h04 || wr_dat[0] !== 32'd300 || wr_adr[1] !== 8'h0C || wr_dat[1] !== 32'd0) begin
            errors++;
            $display("FAIL stop_writes: (%h,%0d) (%h,%0d), required (04,300) (0c,0)",
                     wr_adr[0], wr_dat[0], wr_adr[1], wr_dat[1]);
         end
      end
      checks++;
      if (duty_o !== 16'd0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL stop_final: duty=%0d done=%0b, required 0/0", duty_o, done_o);
      end
      ack_delay = 1;
   endtask

   task automatic test_timeout();
      clear_log();
      nack_en = 1'b1;
      pulse_start(16'd1000, 16'd500, 16'd100, 16'd10);
      wait_idle(100);
      @(negedge clk);
      checks++;
      if (err_o !== 1'b1 || m_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flag: err=%0b stb=%0b, required 1/0", err_o, m_stb_o);
      end
      checks++;
      if (last_run != 16) begin
         errors++;
         $display("FAIL timeout_len: stb high %0d cycles, required 16", last_run);
      end
      checks++;
      if (launches != 2 || wr_adr.size() != 1) begin
         errors++;
         $display("FAIL timeout_no_off: launches=%0d acked=%0d, required 2/1", launches, wr_adr.size());
      end
      nack_en = 1'b0;
      clear_log();
      pulse_start(16'd50, 16'd0, 16'd7, 16'd5);
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_clear: err=%0b busy=%0b, required 0/1", err_o, busy_o);
      end
      wait_done(100);
      checks++;
      if (wr_adr.size() != 4) begin
         errors++;
         $display("FAIL zero_target_count: %0d writes, required 4", wr_adr.size());
      end else begin
         checks++;
         if (wr_dat[0] !== 32'h80 || wr_dat[1] !== 32'd50 || wr_dat[2] !== 32'd0 || wr_dat[3] !== 32'h09) begin
            errors++;
            $display("FAIL zero_target_writes: %h %0d %0d %h, required 80 50 0 09",
                     wr_dat[0], wr_dat[1], wr_dat[2], wr_dat[3]);
         end
      end
   endtask

   task automatic test_edge_cases();
      clear_log();
      pulse_start(16'd0, 16'd3, 16'd0, 16'd0);
      wait_done(100);
      checks++;
      if (wr_adr.size() != 3) begin
         errors++;
         $display("FAIL step0_count: %0d writes, required 3", wr_adr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_adr[i] !== 8'h04 || wr_dat[i] !== 32'(i + 1)) begin
               errors++;
               $display("FAIL step0_write[%0d]: adr=%h dat=%0d, required 04/%0d", i, wr_adr[i], wr_dat[i], i + 1);
            end
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (wr_cyc[i] - wr_cyc[i-1] != 3) begin
               errors++;
               $display("FAIL ivl0_spacing[%0d]: %0d cycles, required 3", i, wr_cyc[i] - wr_cyc[i-1]);
            end
         end
      end
      clear_log();
      pulse_start(16'd0, 16'd3, 16'd5, 16'd5);
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL same_target_hold: done=%0b, required 1", done_o);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (launches != 0 || done_o !== 1'b1 || duty_o !== 16'd3) begin
         errors++;
         $display("FAIL same_target_quiet: launches=%0d done=%0b duty=%0d, required 0/1/3", launches, done_o, duty_o);
      end
   endtask

   task automatic test_async_reset();
      int n = 0;
      pulse_start(16'd10, 16'd300, 16'd100, 16'd30);
      while (duty_o == 16'd3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (duty_o !== 16'd103) begin
         errors++;
         $display("FAIL areset_setup: duty=%0d, required 103", duty_o);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (busy_o !== 1'b0 || duty_o !== 16'd0 || done_o !== 1'b0 || m_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL areset_wait: busy=%0b duty=%0d done=%0b cyc=%0b, required 0", busy_o, duty_o, done_o, m_cyc_o);
      end
      @(negedge clk);
      rst = 1'b0;
      pulse_start(16'd10, 16'd300, 16'd100, 16'd30);
      @(posedge clk);
      #3;
      checks++;
      if (m_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL areset_stb_setup: stb=%0b, required 1", m_stb_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || busy_o !== 1'b0 || m_sel_o !== 4'h0) begin
         errors++;
         $display("FAIL areset_stb: cyc=%0b stb=%0b busy=%0b sel=%h, required 0", m_cyc_o, m_stb_o, busy_o, m_sel_o);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_protocol();
      checks++;
      if (proto_bad !== 1'b0) begin
         errors++;
         $display("FAIL bus_protocol: violation flag=%0b, required 0", proto_bad);
      end
   endtask

   initial begin
      m_ack_i = 1'b0;
      test_reset();
      test_basic_ramp();
      test_retarget_down();
      test_stop_mid_write();
      test_timeout();
      test_edge_cases();
      test_async_reset();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
